// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
package fetch_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {BOOT, FETCH, FLUSH} fetch_state_t;
   localparam word_t DEFAULT_RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, sequences the predictor and inserts flush bubbles on redirect
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter word_t       RESET_PC         = DEFAULT_RESET_PC,
   parameter int unsigned REDIRECT_BUBBLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic [31:0] imem_instr,
   input  logic [31:0] pred_pc,
   input  logic        resolve_valid,
   input  logic        resolve_miss,
   input  logic [31:0] resolve_branch_pc,
   input  logic [31:0] resolve_branch_instr,
   input  logic [31:0] resolve_target,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic        fetch_fire,
   output logic [31:0] cur_pc,
   output logic [31:0] cur_instr,
   output logic        pred_en,
   output logic        miss,
   output logic [31:0] prev_pc,
   output logic [31:0] prev_instr,
   output logic [31:0] miss_count
);
   localparam logic [2:0] BUBBLES = 3'(REDIRECT_BUBBLES);
   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d, prev_pc_q, prev_pc_d, prev_instr_q, prev_instr_d, miss_count_q, miss_count_d;
   logic [2:0]   cnt_q, cnt_d;
   logic         miss_q, redirect;
   assign redirect    = resolve_valid & resolve_miss;
   assign fetch_valid = state_q == FETCH;
   assign fetch_fire  = fetch_valid & imem_ready & ~stall & ~redirect;
   assign pred_en     = fetch_fire;
   assign fetch_pc    = pc_q;
   assign cur_pc      = pc_q;
   assign cur_instr   = imem_instr;
   assign miss        = miss_q;
   assign prev_pc     = prev_pc_q;
   assign prev_instr  = prev_instr_q;
   assign miss_count  = miss_count_q;
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      cnt_d        = cnt_q;
      miss_count_d = miss_count_q;
      prev_pc_d    = resolve_valid ? resolve_branch_pc : prev_pc_q;
      prev_instr_d = resolve_valid ? resolve_branch_instr : prev_instr_q;
      if (redirect) begin
         pc_d         = {resolve_target[31:2], 2'b00};
         cnt_d        = BUBBLES;
         state_d      = (BUBBLES == 3'd0) ? FETCH : FLUSH;
         miss_count_d = miss_count_q + 32'd1;
      end else begin
         pc_d    = fetch_fire ? {pred_pc[31:2], 2'b00} : pc_q;
         cnt_d   = (state_q == FLUSH) ? cnt_q - 3'd1 : cnt_q;
         // BOOT and FETCH both land in FETCH; FLUSH leaves once the last bubble is spent
         state_d = (state_q == FLUSH && cnt_q > 3'd1) ? FLUSH : FETCH;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         cnt_q        <= 3'd0;
         miss_q       <= 1'b0;
         prev_pc_q    <= '0;
         prev_instr_q <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         miss_q       <= redirect;
         prev_pc_q    <= prev_pc_d;
         prev_instr_q <= prev_instr_d;
         miss_count_q <= miss_count_d;
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch sequencing, back-pressure, redirect and flush behaviour
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        reset_n, stall, imem_ready, resolve_valid, resolve_miss;
   logic [31:0] imem_instr, pred_pc, resolve_branch_pc, resolve_branch_instr, resolve_target;
   logic [31:0] fetch_pc, cur_pc, cur_instr, prev_pc, prev_instr, miss_count;
   logic        fetch_valid, fetch_fire, pred_en, miss;
   logic [31:0] fetch_pc3, cur_pc3, cur_instr3, prev_pc3, prev_instr3, miss_count3;
   logic        fetch_valid3, fetch_fire3, pred_en3, miss3;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   fetch_sequencer dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .imem_ready(imem_ready), .imem_instr(imem_instr),
      .pred_pc(pred_pc), .resolve_valid(resolve_valid), .resolve_miss(resolve_miss),
      .resolve_branch_pc(resolve_branch_pc), .resolve_branch_instr(resolve_branch_instr),
      .resolve_target(resolve_target), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
      .fetch_fire(fetch_fire), .cur_pc(cur_pc), .cur_instr(cur_instr), .pred_en(pred_en), .miss(miss),
      .prev_pc(prev_pc), .prev_instr(prev_instr), .miss_count(miss_count));
   fetch_sequencer #(.REDIRECT_BUBBLES(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .stall(stall), .imem_ready(imem_ready), .imem_instr(imem_instr),
      .pred_pc(pred_pc), .resolve_valid(resolve_valid), .resolve_miss(resolve_miss),
      .resolve_branch_pc(resolve_branch_pc), .resolve_branch_instr(resolve_branch_instr),
      .resolve_target(resolve_target), .fetch_pc(fetch_pc3), .fetch_valid(fetch_valid3),
      .fetch_fire(fetch_fire3), .cur_pc(cur_pc3), .cur_instr(cur_instr3), .pred_en(pred_en3), .miss(miss3),
      .prev_pc(prev_pc3), .prev_instr(prev_instr3), .miss_count(miss_count3));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      reset_n = 1'b0; stall = 1'b0; imem_ready = 1'b1; imem_instr = 32'h0000_0013;
      pred_pc = 32'h3004; resolve_valid = 1'b0; resolve_miss = 1'b0;
      resolve_branch_pc = '0; resolve_branch_instr = '0; resolve_target = '0;
      tick(); tick();
      checks++; if (fetch_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", fetch_pc, 32'h3000); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
      checks++; if (fetch_fire !== 1'b0 || pred_en !== 1'b0) begin errors++; $display("FAIL reset_fire got %b/%b exp 0/0", fetch_fire, pred_en); end
      checks++; if (miss !== 1'b0 || prev_pc !== 32'h0 || prev_instr !== 32'h0 || miss_count !== 32'h0) begin
         errors++; $display("FAIL reset_feedback got %b %h %h %h exp 0 0 0 0", miss, prev_pc, prev_instr, miss_count); end
      @(negedge clk); reset_n = 1'b1; #1;
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", fetch_valid); end
      tick();
      checks++; if (fetch_pc !== 32'h3000 || fetch_valid !== 1'b1 || fetch_fire !== 1'b1) begin
         errors++; $display("FAIL first_fetch got %h %b %b exp 3000 1 1", fetch_pc, fetch_valid, fetch_fire); end
      checks++; if (cur_pc !== 32'h3000 || cur_instr !== 32'h0000_0013) begin
         errors++; $display("FAIL cur_pass got %h %h exp 3000 00000013", cur_pc, cur_instr); end
   endtask
   task automatic test_fetch();
      tick();
      checks++; if (fetch_pc !== 32'h3004 || fetch_fire !== 1'b1) begin errors++; $display("FAIL fetch_3004 got %h %b", fetch_pc, fetch_fire); end
      pred_pc = 32'h300A;
      tick();
      checks++; if (fetch_pc !== 32'h3008 || fetch_fire !== 1'b1) begin errors++; $display("FAIL fetch_3008_aligned got %h %b", fetch_pc, fetch_fire); end
   endtask
   task automatic test_backpressure();
      logic [1:0] bp [3] = '{2'b11, 2'b00, 2'b10};
      pred_pc = 32'h300C;
      for (int i = 0; i < 3; i++) begin
         stall = bp[i][1]; imem_ready = bp[i][0]; #1;
         checks++; if (fetch_fire !== 1'b0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL bp_fire[%0d] got %b/%b exp 0/1", i, fetch_fire, fetch_valid); end
         tick();
         checks++; if (fetch_pc !== 32'h3008) begin errors++; $display("FAIL bp_hold[%0d] got %h exp 3008", i, fetch_pc); end
      end
      stall = 1'b0; imem_ready = 1'b1; #1;
      checks++; if (fetch_fire !== 1'b1) begin errors++; $display("FAIL bp_release_fire got %b exp 1", fetch_fire); end
      tick();
      checks++; if (fetch_pc !== 32'h300C) begin errors++; $display("FAIL bp_advance got %h exp 300c", fetch_pc); end
   endtask
   task automatic test_redirect();
      stall = 1'b1; resolve_valid = 1'b1; resolve_miss = 1'b1;
      resolve_target = 32'h3103; resolve_branch_pc = 32'h3004; resolve_branch_instr = 32'hDEAD_BEEF; #1;
      checks++; if (fetch_fire !== 1'b0) begin errors++; $display("FAIL redir_fire got %b exp 0", fetch_fire); end
      tick();
      resolve_valid = 1'b0; resolve_miss = 1'b0; stall = 1'b0; #1;
      checks++; if (fetch_pc !== 32'h3100 || fetch_valid !== 1'b0) begin errors++; $display("FAIL redir_pc got %h %b exp 3100 0", fetch_pc, fetch_valid); end
      checks++; if (miss !== 1'b1 || prev_pc !== 32'h3004 || prev_instr !== 32'hDEAD_BEEF || miss_count !== 32'd1) begin
         errors++; $display("FAIL redir_fb got %b %h %h %0d exp 1 3004 deadbeef 1", miss, prev_pc, prev_instr, miss_count); end
      pred_pc = 32'h3104;
      tick();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h3100 || miss !== 1'b0) begin
         errors++; $display("FAIL redir_refetch got %b %h %b exp 1 3100 0", fetch_valid, fetch_pc, miss); end
      tick();
      checks++; if (fetch_pc !== 32'h3104) begin errors++; $display("FAIL redir_follow got %h exp 3104", fetch_pc); end
   endtask
   task automatic test_correct_pred();
      resolve_valid = 1'b1; resolve_miss = 1'b0; resolve_branch_pc = 32'h3050;
      resolve_branch_instr = 32'h1234_5678; resolve_target = 32'h9990; pred_pc = 32'h3200;
      tick();
      resolve_valid = 1'b0; #1;
      checks++; if (fetch_pc !== 32'h3200 || fetch_valid !== 1'b1 || miss !== 1'b0) begin
         errors++; $display("FAIL hit_pc got %h %b %b exp 3200 1 0", fetch_pc, fetch_valid, miss); end
      checks++; if (prev_pc !== 32'h3050 || prev_instr !== 32'h1234_5678 || miss_count !== 32'd1) begin
         errors++; $display("FAIL hit_fb got %h %h %0d exp 3050 12345678 1", prev_pc, prev_instr, miss_count); end
   endtask
   task automatic test_async_reset();
      resolve_valid = 1'b1; resolve_miss = 1'b1; resolve_target = 32'h7000; resolve_branch_pc = 32'h3200;
      tick();
      resolve_valid = 1'b0; resolve_miss = 1'b0; #1;
      checks++; if (fetch_valid !== 1'b0 || miss_count !== 32'd2) begin errors++; $display("FAIL pre_areset got %b %0d exp 0 2", fetch_valid, miss_count); end
      #1 reset_n = 1'b0; #1;
      checks++; if (fetch_pc !== 32'h3000 || miss !== 1'b0 || miss_count !== 32'd0 || prev_pc !== 32'h0) begin
         errors++; $display("FAIL areset got %h %b %0d %h exp 3000 0 0 0", fetch_pc, miss, miss_count, prev_pc); end
      tick();
      checks++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h3000) begin errors++; $display("FAIL areset_hold got %b %h exp 0 3000", fetch_valid, fetch_pc); end
   endtask
   task automatic test_back_to_back();
      @(negedge clk); reset_n = 1'b1; pred_pc = 32'h3004;
      tick();
      checks++; if (fetch_valid3 !== 1'b1 || fetch_pc3 !== 32'h3000) begin errors++; $display("FAIL b3_start got %b %h exp 1 3000", fetch_valid3, fetch_pc3); end
      resolve_valid = 1'b1; resolve_miss = 1'b1; resolve_target = 32'h4000;
      tick();
      resolve_valid = 1'b0; resolve_miss = 1'b0; #1;
      checks++; if (fetch_pc3 !== 32'h4000 || fetch_valid3 !== 1'b0 || miss3 !== 1'b1 || miss_count3 !== 32'd1) begin
         errors++; $display("FAIL b3_first got %h %b %b %0d exp 4000 0 1 1", fetch_pc3, fetch_valid3, miss3, miss_count3); end
      tick();
      checks++; if (fetch_valid3 !== 1'b0 || miss3 !== 1'b0) begin errors++; $display("FAIL b3_gap got %b %b exp 0 0", fetch_valid3, miss3); end
      resolve_valid = 1'b1; resolve_miss = 1'b1; resolve_target = 32'h500B;
      tick();
      resolve_valid = 1'b0; resolve_miss = 1'b0; #1;
      checks++; if (fetch_pc3 !== 32'h5008 || miss3 !== 1'b1 || miss_count3 !== 32'd2) begin
         errors++; $display("FAIL b3_second got %h %b %0d exp 5008 1 2", fetch_pc3, miss3, miss_count3); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (fetch_valid3 !== 1'b0) begin errors++; $display("FAIL b3_bubble[%0d] got %b exp 0", i, fetch_valid3); end
         tick();
      end
      checks++; if (fetch_valid3 !== 1'b1 || fetch_pc3 !== 32'h5008 || miss3 !== 1'b0) begin
         errors++; $display("FAIL b3_refetch got %b %h %b exp 1 5008 0", fetch_valid3, fetch_pc3, miss3); end
   endtask
   initial begin
      test_reset();
      test_fetch();
      test_backpressure();
      test_redirect();
      test_correct_pred();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that owns the architectural fetch PC and sequences the frontend predictor. Each cycle it either advances to the predictor's target, holds on stall or instruction-memory back-pressure, or redirects to a corrected target on a backend mispredict and inserts flush bubbles. It also registers the resolved-branch feedback (miss, prev_pc, prev_instr) that the predictor consumes. It sits between instruction memory, the frontend predictor and the branch-resolution stage.

## Interface
- RESET_PC, 32'h0000_3000, fetch address after reset.
- REDIRECT_BUBBLES, 1, invalid fetch cycles after a redirect (0–7).
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  backend cannot accept an instruction this cycle.
- imem_ready  in  1  imem_instr is valid for fetch_pc.
- imem_instr  in  32  instruction word at fetch_pc.
- pred_pc  in  32  predictor target for (cur_pc, cur_instr).
- resolve_valid  in  1  a control-flow instruction resolved this cycle.
- resolve_miss  in  1  that resolution disagreed with the prediction.
- resolve_branch_pc  in  32  PC of the resolved instruction.
- resolve_branch_instr  in  32  the resolved instruction word.
- resolve_target  in  32  correct next PC.
- fetch_pc  out  32  current fetch address (PC register).
- fetch_valid  out  1  instruction at fetch_pc is offered downstream.
- fetch_fire  out  1  instruction accepted this cycle.
- cur_pc, cur_instr  out  32 each  to predictor; equal fetch_pc and imem_instr.
- pred_en  out  1  predictor enable; equals fetch_fire.
- miss, prev_pc, prev_instr  out  1/32/32  registered resolution feedback to predictor.
- miss_count  out  32  number of redirects since reset; wraps.

## Operation
- States: BOOT, FETCH, FLUSH.
- Reset (asynchronous): state=BOOT, pc=RESET_PC, flush_cnt=0, miss=0, prev_pc=0, prev_instr=0, miss_count=0. Consequently fetch_valid=0 and fetch_fire=0.
- BOOT: fetch_valid=0. Go to FETCH next cycle unless a redirect occurs.
- FETCH: fetch_valid=1. fetch_fire = fetch_valid & imem_ready & !stall & !redirect. On fire, pc <= {pred_pc[31:2],2'b00}. Otherwise pc holds.
- Redirect = resolve_valid & resolve_miss. It is legal in any state and has priority over fire and stall.
  - pc <= {resolve_target[31:2],2'b00}.
  - miss_count increments, wrapping modulo 2^32.
  - If REDIRECT_BUBBLES=0, go to FETCH. Otherwise go to FLUSH with flush_cnt=REDIRECT_BUBBLES.
- FLUSH: fetch_valid=0. flush_cnt decrements each cycle. Leave for FETCH on the cycle flush_cnt==1 decrements to 0. A redirect during FLUSH reloads pc and flush_cnt and counts again.
- Feedback registers:
  - On every resolve_valid, prev_pc <= resolve_branch_pc and prev_instr <= resolve_branch_instr.
  - miss <= redirect every cycle, so miss is a one-cycle pulse unless redirects are back-to-back.
  - If resolve_valid=0, prev_pc and prev_instr hold.
- stall alone never changes state or pc.

## Timing
- Combinational paths: fetch_valid, fetch_fire and pred_en from state and inputs. cur_pc and cur_instr are direct pass-through.
- pred_pc is consumed in the same cycle as fire. The next fetch_pc is visible one cycle after fire.
- Redirect-to-refetch latency is 1 + REDIRECT_BUBBLES cycles. With the default, fetch_valid=0 for exactly one cycle after redirect.
- miss, prev_pc and prev_instr update one cycle after the resolution.
- Reset deasserted: one BOOT cycle, then the first fetch at RESET_PC.
- Reset asserted mid-FLUSH or mid-stall returns immediately to BOOT values. No pending redirect survives reset.

## Structure
- Shared package fetch_pkg holds:
  - enum fetch_state_t {BOOT, FETCH, FLUSH}, 2 bits;
  - constant DEFAULT_RESET_PC = 32'h0000_3000;
  - typedef word_t = logic [31:0].
- Single flat module, no sub-module. The predictor is a sibling connected at the frontend top level.

## Test plan
- Reset release: reset_n low then high, imem_ready=1, pred_pc=pc+4 → one BOOT cycle, then fetch_pc 0x3000, 0x3004, 0x3008 with fetch_fire=1 each cycle.
- Back-pressure: stall=1 or imem_ready=0 for 3 cycles at fetch_pc=0x3008 → fetch_pc holds, fetch_fire=0; advances to 0x300C on the first accepting cycle.
- Redirect: resolve_valid=1, resolve_miss=1, resolve_target=0x3103, branch_pc=0x3004 while stall=1 →
  - next cycle: fetch_pc=0x3100, fetch_valid=0, miss=1, prev_pc=0x3004, miss_count=1;
  - the cycle after: fetch_valid=1.
- Redirect during FLUSH with REDIRECT_BUBBLES=3: second miss two cycles after the first → pc takes the second target, flush restarts (3 invalid cycles), miss_count=2, miss high for two separate pulses.
- Correct prediction: resolve_valid=1, resolve_miss=0 → miss=0, prev_pc and prev_instr update, pc follows pred_pc, miss_count unchanged.
- Async reset mid-FLUSH: reset_n low between clock edges → outputs at reset values immediately, before the next edge; miss_count=0.
